// File: rtl/window_analysis_pkg.sv
// Shared widths, frame constants and FSM encodings for the window_analysis result path.
package window_analysis_pkg;

    localparam int unsigned SAMPLE_DATA_SIZE     = 12;
    localparam int unsigned WINDOW_POW_SIZE      = 12;
    localparam int unsigned CYCLE_NUMBER_SIZE    = 10;
    localparam int unsigned READ_DATA_SIZE       = WINDOW_POW_SIZE + 2 * SAMPLE_DATA_SIZE
                                                   + CYCLE_NUMBER_SIZE;
    localparam int unsigned RECORD_SIZE          = 48;
    localparam int unsigned DEFAULT_READ_LATENCY = 2;
    localparam int unsigned FRAME_BYTES          = 8;
    localparam int unsigned LAT_CNT_W            = 3;
    localparam int unsigned BYTE_IDX_W           = 3;
    localparam int unsigned RECORDS_W            = 16;
    localparam int unsigned STATE_W              = 3;

    localparam logic [7:0] FRAME_HEADER = 8'hA5;

    // Bit positions inside fifo_state_in
    localparam int unsigned FIFO_FULL   = 3;
    localparam int unsigned FIFO_EMPTY  = 2;
    localparam int unsigned FIFO_AFULL  = 1;
    localparam int unsigned FIFO_AEMPTY = 0;

    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_REQ  = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT = 3'd2;
    localparam logic [STATE_W-1:0] ST_SEND = 3'd3;
    localparam logic [STATE_W-1:0] ST_GAP  = 3'd4;

    // XOR of the six record bytes
    function automatic logic [7:0] record_checksum(input logic [RECORD_SIZE-1:0] rec);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 6; i++) begin
            acc = acc ^ rec[8*i +: 8];
        end
        return acc;
    endfunction

    // Frame byte for a given index: header, record MSB first, checksum
    function automatic logic [7:0] frame_byte(input logic [BYTE_IDX_W-1:0] idx,
                                              input logic [RECORD_SIZE-1:0] rec,
                                              input logic [7:0]             chk);
        logic [7:0] b;
        case (idx)
            3'd0:    b = FRAME_HEADER;
            3'd1:    b = rec[47:40];
            3'd2:    b = rec[39:32];
            3'd3:    b = rec[31:24];
            3'd4:    b = rec[23:16];
            3'd5:    b = rec[15:8];
            3'd6:    b = rec[7:0];
            default: b = chk;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/window_result_reader.sv
// Pops one record per frame from the window_analysis FIFO and streams it as an 8-byte frame.
module window_result_reader
    import window_analysis_pkg::*;
#(
    parameter int unsigned READ_LATENCY = DEFAULT_READ_LATENCY
) (
    input  logic                      clk,
    input  logic                      nrst_in,
    input  logic                      enable_in,
    input  logic                      clear_in,
    input  logic [3:0]                fifo_state_in,
    input  logic [READ_DATA_SIZE-1:0] read_data_in,
    output logic                      read_enable_out,
    output logic [7:0]                byte_data_out,
    output logic                      byte_valid_out,
    input  logic                      byte_ready_in,
    output logic                      busy_out,
    output logic                      overflow_out,
    output logic [RECORDS_W-1:0]      records_sent_out
);

    logic [STATE_W-1:0]     state_q,    state_d;
    logic [LAT_CNT_W-1:0]   lat_cnt_q,  lat_cnt_d;
    logic [BYTE_IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic [RECORD_SIZE-1:0] record_q,   record_d;
    logic [7:0]             chk_q,      chk_d;
    logic                   rd_en_q,    rd_en_d;
    logic                   valid_q,    valid_d;
    logic [7:0]             data_q,     data_d;
    logic                   busy_q,     busy_d;
    logic                   ovf_q,      ovf_d;
    logic [RECORDS_W-1:0]   sent_q,     sent_d;
    logic                   accept_c;
    logic                   unused_fifo_flags;

    assign accept_c          = valid_q && byte_ready_in;
    assign unused_fifo_flags = fifo_state_in[FIFO_AFULL] ^ fifo_state_in[FIFO_AEMPTY];

    // Next-state, frame sequencing and status counters
    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        byte_idx_d = byte_idx_q;
        record_d   = record_q;
        chk_d      = chk_q;
        rd_en_d    = 1'b0;
        valid_d    = 1'b0;
        data_d     = 8'h00;
        sent_d     = sent_q;
        ovf_d      = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (enable_in && !fifo_state_in[FIFO_EMPTY]) begin
                    state_d = ST_REQ;
                    rd_en_d = 1'b1;
                end
            end
            ST_REQ: begin
                state_d   = ST_WAIT;
                lat_cnt_d = LAT_CNT_W'(READ_LATENCY - 1);
            end
            ST_WAIT: begin
                if (lat_cnt_q == '0) begin
                    record_d   = RECORD_SIZE'(read_data_in);
                    chk_d      = record_checksum(record_d);
                    byte_idx_d = '0;
                    state_d    = ST_SEND;
                    valid_d    = 1'b1;
                    data_d     = FRAME_HEADER;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
                end
            end
            ST_SEND: begin
                valid_d = 1'b1;
                data_d  = data_q;
                if (accept_c) begin
                    if (byte_idx_q == BYTE_IDX_W'(FRAME_BYTES - 1)) begin
                        state_d = ST_GAP;
                        valid_d = 1'b0;
                        data_d  = 8'h00;
                        sent_d  = sent_q + RECORDS_W'(1);
                    end else begin
                        byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
                        data_d     = frame_byte(byte_idx_d, record_q, chk_q);
                    end
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enable_in && fifo_state_in[FIFO_FULL]) begin
            ovf_d = 1'b1;
        end
        if (clear_in) begin
            ovf_d  = 1'b0;
            sent_d = '0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge nrst_in) begin
        if (!nrst_in) begin
            state_q    <= ST_IDLE;
            lat_cnt_q  <= '0;
            byte_idx_q <= '0;
            record_q   <= '0;
            chk_q      <= '0;
            rd_en_q    <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            sent_q     <= '0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            byte_idx_q <= byte_idx_d;
            record_q   <= record_d;
            chk_q      <= chk_d;
            rd_en_q    <= rd_en_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
            sent_q     <= sent_d;
        end
    end

    assign read_enable_out  = rd_en_q;
    assign byte_data_out    = data_q;
    assign byte_valid_out   = valid_q;
    assign busy_out         = busy_q;
    assign overflow_out     = ovf_q;
    assign records_sent_out = sent_q;

endmodule

// File: tb/tb_window_result_reader.sv
// Bench: FIFO + sink model around window_result_reader, frames checked against record arithmetic.
module tb_window_result_reader;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        nrst_in;
    logic        enable_in;
    logic        clear_in;
    logic [3:0]  fifo_state_in;
    logic [45:0] read_data_in;
    logic        read_enable_out;
    logic [7:0]  byte_data_out;
    logic        byte_valid_out;
    logic        byte_ready_in;
    logic        busy_out;
    logic        overflow_out;
    logic [15:0] records_sent_out;

    window_result_reader #(.READ_LATENCY(LAT)) dut (
        .clk              (clk),
        .nrst_in          (nrst_in),
        .enable_in        (enable_in),
        .clear_in         (clear_in),
        .fifo_state_in    (fifo_state_in),
        .read_data_in     (read_data_in),
        .read_enable_out  (read_enable_out),
        .byte_data_out    (byte_data_out),
        .byte_valid_out   (byte_valid_out),
        .byte_ready_in    (byte_ready_in),
        .busy_out         (busy_out),
        .overflow_out     (overflow_out),
        .records_sent_out (records_sent_out)
    );

    always #5 clk = ~clk;

    // Model state
    logic [45:0] fifo_q[$];
    logic [45:0] popped_q[$];
    logic [7:0]  rx_q[$];
    int          rd_cycles[$];
    logic        force_full = 1'b0;
    logic        fifo_empty = 1'b1;
    int          ready_mode = 0;
    int          cyc = 0;
    int          rd_count = 0;
    int          rd_on_empty = 0;
    int          stall_err = 0;
    logic        pend_valid = 1'b0;
    int          pend_cyc = 0;
    logic [45:0] pend_data;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;

    assign fifo_state_in = {force_full, fifo_empty, 1'b0, 1'b0};

    // FIFO with fixed read latency plus byte sink, evaluated just after each rising edge
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (!nrst_in) begin
            pend_valid   = 1'b0;
            prev_stall   = 1'b0;
            read_data_in = 'x;
        end else begin
            if (pend_valid && cyc == pend_cyc) begin
                read_data_in = pend_data;
                pend_valid   = 1'b0;
            end else begin
                read_data_in = 'x;
            end
            if (read_enable_out) begin
                rd_count = rd_count + 1;
                rd_cycles.push_back(cyc);
                if (fifo_q.size() == 0) begin
                    rd_on_empty = rd_on_empty + 1;
                end else begin
                    pend_data  = fifo_q.pop_front();
                    popped_q.push_back(pend_data);
                    pend_valid = 1'b1;
                    pend_cyc   = cyc + LAT;
                end
            end
            case (ready_mode)
                0:       byte_ready_in = 1'b1;
                1:       byte_ready_in = 1'($urandom_range(0, 1));
                2:       byte_ready_in = (cyc % 3 == 0);
                default: byte_ready_in = 1'b0;
            endcase
            if (prev_stall && !(byte_valid_out && byte_data_out == prev_data)) begin
                stall_err = stall_err + 1;
            end
            if (byte_valid_out && byte_ready_in) begin
                rx_q.push_back(byte_data_out);
            end
            prev_stall = byte_valid_out && !byte_ready_in;
            prev_data  = byte_data_out;
        end
        fifo_empty = (fifo_q.size() == 0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_bad = n_bad + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected frame byte straight from the record value
    function automatic logic [7:0] exp_byte(input logic [45:0] rec, input int b);
        logic [47:0] r;
        logic [7:0]  x;
        r = {2'b00, rec};
        if (b == 0) return 8'hA5;
        if (b <= 6) return r[8*(6-b) +: 8];
        x = 8'h00;
        for (int k = 0; k < 6; k++) x = x ^ r[8*k +: 8];
        return x;
    endfunction

    task automatic check_frames(input string tag);
        chk({tag, "_len"}, 64'(rx_q.size()), 64'(8 * popped_q.size()));
        for (int i = 0; i < popped_q.size(); i++) begin
            for (int b = 0; b < 8; b++) begin
                if (8 * i + b < rx_q.size()) begin
                    chk($sformatf("%s_f%0d_b%0d", tag, i, b), 64'(rx_q[8*i+b]),
                        64'(exp_byte(popped_q[i], b)));
                end
            end
        end
    endtask

    task automatic wait_sent(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (records_sent_out != 16'(n) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_sent"}, 64'(records_sent_out), 64'(n));
    endtask

    task automatic rnd_rec(output logic [45:0] r);
        r = {14'($urandom), 32'($urandom)};
    endtask

    initial begin
        logic [45:0] r;
        int r0;
        int k;

        nrst_in       = 1'b0;
        enable_in     = 1'b0;
        clear_in      = 1'b0;
        byte_ready_in = 1'b0;
        read_data_in  = 'x;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rd",    64'(read_enable_out),  64'd0);
        chk("rst_valid", 64'(byte_valid_out),   64'd0);
        chk("rst_data",  64'(byte_data_out),    64'd0);
        chk("rst_busy",  64'(busy_out),         64'd0);
        chk("rst_ovf",   64'(overflow_out),     64'd0);
        chk("rst_sent",  64'(records_sent_out), 64'd0);
        nrst_in = 1'b1;
        repeat (2) @(negedge clk);

        // Single directed record, then one random record with random ready
        fifo_q.push_back(46'h2_1234_5678_9A);
        enable_in = 1'b1;
        wait_sent(1, 100, "single");
        chk("single_reads", 64'(rd_count), 64'd1);
        check_frames("single");
        ready_mode = 1;
        rnd_rec(r);
        fifo_q.push_back(r);
        wait_sent(2, 300, "rndready");

        // Backpressure pattern 1,0,0
        ready_mode = 2;
        rnd_rec(r); fifo_q.push_back(r);
        rnd_rec(r); fifo_q.push_back(r);
        wait_sent(4, 300, "bp");
        chk("bp_stall", 64'(stall_err), 64'd0);
        check_frames("bp");

        // Three queued records back to back
        ready_mode = 0;
        repeat (3) @(negedge clk);
        rd_cycles.delete();
        for (int i = 0; i < 3; i++) begin
            rnd_rec(r);
            fifo_q.push_back(r);
        end
        wait_sent(7, 200, "b2b");
        chk("b2b_npulse", 64'(rd_cycles.size()), 64'd3);
        if (rd_cycles.size() == 3) begin
            chk("b2b_gap1", 64'(rd_cycles[1] - rd_cycles[0]), 64'(8 + LAT + 3));
            chk("b2b_gap2", 64'(rd_cycles[2] - rd_cycles[1]), 64'(8 + LAT + 3));
        end
        check_frames("b2b");

        // Enable dropped mid-frame
        r0 = rd_count;
        k  = rx_q.size();
        rnd_rec(r); fifo_q.push_back(r);
        rnd_rec(r); fifo_q.push_back(r);
        while (rx_q.size() < k + 4 && cyc < 20000) @(negedge clk);
        enable_in = 1'b0;
        repeat (40) @(negedge clk);
        chk("dis_sent",  64'(records_sent_out), 64'd8);
        chk("dis_reads", 64'(rd_count),         64'(r0 + 1));
        chk("dis_left",  64'(fifo_q.size()),    64'd1);
        chk("dis_busy",  64'(busy_out),         64'd0);
        check_frames("dis");

        // Overflow: ignored while disabled, sticky while enabled, clear wins
        force_full = 1'b1;
        repeat (3) @(negedge clk);
        chk("ovf_disabled", 64'(overflow_out), 64'd0);
        enable_in = 1'b1;
        @(negedge clk);
        chk("ovf_set", 64'(overflow_out), 64'd1);
        force_full = 1'b0;
        repeat (2) @(negedge clk);
        chk("ovf_sticky", 64'(overflow_out), 64'd1);
        clear_in   = 1'b1;
        force_full = 1'b1;
        @(negedge clk);
        clear_in   = 1'b0;
        force_full = 1'b0;
        chk("ovf_clear", 64'(overflow_out),     64'd0);
        chk("cnt_clear", 64'(records_sent_out), 64'd0);
        wait_sent(1, 100, "post_clear");
        check_frames("post_clear");

        // Reset in the middle of a stalled frame
        ready_mode = 3;
        rnd_rec(r); fifo_q.push_back(r);
        k = 0;
        while (!byte_valid_out && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("mid_valid", 64'(byte_valid_out), 64'd1);
        #3;
        nrst_in = 1'b0;
        #1;
        chk("arst_valid", 64'(byte_valid_out),   64'd0);
        chk("arst_data",  64'(byte_data_out),    64'd0);
        chk("arst_busy",  64'(busy_out),         64'd0);
        chk("arst_sent",  64'(records_sent_out), 64'd0);
        chk("arst_rd",    64'(read_enable_out),  64'd0);
        repeat (2) @(negedge clk);
        rx_q.delete();
        popped_q.delete();
        r0 = rd_count;
        nrst_in    = 1'b1;
        ready_mode = 0;
        repeat (20) @(negedge clk);
        chk("post_rst_rx",    64'(rx_q.size()),   64'd0);
        chk("post_rst_reads", 64'(rd_count),      64'(r0));
        chk("post_rst_valid", 64'(byte_valid_out), 64'd0);
        rnd_rec(r); fifo_q.push_back(r);
        wait_sent(1, 100, "restart");
        check_frames("restart");

        chk("rd_on_empty", 64'(rd_on_empty), 64'd0);
        chk("stall_total", 64'(stall_err),   64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
